// File: rtl/wptr_full_ctrl_if.sv
// Write-side bus for the async FIFO pointer/flag block.
// The master modport is the producer; the slave modport is the controller.
interface wptr_full_ctrl_if #(
  parameter int unsigned ADDRSIZE = 4
);
  logic                winc;
  logic [ADDRSIZE:0]   wd_rptr;
  logic                wovf_clr;
  logic [ADDRSIZE-1:0] waddr;
  logic [ADDRSIZE:0]   wptr;
  logic                wfull;
  logic                walmost_full;
  logic [ADDRSIZE:0]   wlevel;
  logic                woverflow;

  modport master (
    output winc, wd_rptr, wovf_clr,
    input  waddr, wptr, wfull, walmost_full, wlevel, woverflow
  );

  modport slave (
    input  winc, wd_rptr, wovf_clr,
    output waddr, wptr, wfull, walmost_full, wlevel, woverflow
  );
endinterface

// File: rtl/wptr_full_ctrl.sv
// Write-domain pointer, Gray export and registered full/almost-full/level/overflow
// status for the asynchronous FIFO, all in wclk.
module wptr_full_ctrl #(
  parameter int unsigned ADDRSIZE    = 4,
  parameter int unsigned AFULL_LEVEL = (1 << ADDRSIZE) - 2
) (
  input logic              wclk,
  input logic              wrst,
  wptr_full_ctrl_if.slave  bus
);
  localparam logic [ADDRSIZE:0] AFULL_THR = (ADDRSIZE + 1)'(AFULL_LEVEL);

  logic [ADDRSIZE:0] wbin;
  logic [ADDRSIZE:0] wbinnext;
  logic [ADDRSIZE:0] wgraynext;
  logic [ADDRSIZE:0] rbin;
  logic [ADDRSIZE:0] level_next;
  logic [ADDRSIZE:0] wptr_q;
  logic [ADDRSIZE:0] wlevel_q;
  logic              wfull_q;
  logic              wafull_q;
  logic              wovf_q;
  logic              wen;
  logic              full_next;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    rbin = '0;
    for (int unsigned i = 0; i <= ADDRSIZE; i++) begin
      rbin[i] = ^(bus.wd_rptr >> i);
    end
  end

  assign wen        = bus.winc & ~wfull_q;
  assign wbinnext   = wbin + (ADDRSIZE + 1)'(wen);
  assign wgraynext  = (wbinnext >> 1) ^ wbinnext;
  assign level_next = wbinnext - rbin;
  assign full_next  = (wgraynext == {~bus.wd_rptr[ADDRSIZE:ADDRSIZE-1],
                                     bus.wd_rptr[ADDRSIZE-2:0]});

  always_ff @(posedge wclk or negedge wrst) begin
    if (!wrst) begin
      wbin     <= '0;
      wptr_q   <= '0;
      wfull_q  <= 1'b0;
      wafull_q <= 1'b0;
      wlevel_q <= '0;
    end else begin
      wbin     <= wbinnext;
      wptr_q   <= wgraynext;
      wfull_q  <= full_next;
      wafull_q <= (level_next >= AFULL_THR);
      wlevel_q <= level_next;
    end
  end

  // Sticky overflow: a rejected write outranks a clear in the same cycle.
  always_ff @(posedge wclk or negedge wrst) begin
    if (!wrst) begin
      wovf_q <= 1'b0;
    end else if (bus.winc & wfull_q) begin
      wovf_q <= 1'b1;
    end else if (bus.wovf_clr) begin
      wovf_q <= 1'b0;
    end
  end

  assign bus.waddr        = wbin[ADDRSIZE-1:0];
  assign bus.wptr         = wptr_q;
  assign bus.wfull        = wfull_q;
  assign bus.walmost_full = wafull_q;
  assign bus.wlevel       = wlevel_q;
  assign bus.woverflow    = wovf_q;
endmodule
